// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-1 master.
package spi_pkg;
  localparam int SPI_MIN_DIV    = 8;
  localparam int SPI_MAX_DIV    = 65535;
  localparam int SPI_FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_HI, SCK_LO, BURST_WAIT, HOLD, GAP
  } spi_mst_state_t;
endpackage

// File: rtl/spi_master_if.sv
// Byte stream plus SPI pins of spi_master; master = the SPI controller side.
interface spi_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;

  modport master (input  tx_data, tx_valid, tx_last, miso,
                  output tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi);
  modport slave  (output tx_data, tx_valid, tx_last, miso,
                  input  tx_ready, rx_data, rx_valid, busy, sclk, cs, mosi);
endinterface

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module spi_half_period_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/spi_master.sv
// SPI mode 1 (CPOL=0, CPHA=1) master, MSB first, 8-bit frames with CS-held bursts.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  if (CLK_DIV < SPI_MIN_DIV || CLK_DIV > SPI_MAX_DIV) begin : g_bad_div
    $error("spi_master: CLK_DIV=%0d outside [%0d,%0d]", CLK_DIV, SPI_MIN_DIV, SPI_MAX_DIV);
  end

  // Timer is loaded with N-1 so that each timed state lasts exactly N cycles.
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  spi_mst_state_t state;
  logic [7:0] tx_sh, rx_sh, rx_data_q;
  logic [2:0] bit_cnt;
  logic       last_q, cs_q, sclk_q, mosi_q, rx_valid_q;
  logic       miso_q1, miso_q2;
  logic       tmr_load, tmr_exp, accept;

  assign bus.tx_ready = (state == IDLE || state == BURST_WAIT) && !rst;
  assign bus.busy     = (state != IDLE);
  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign accept       = bus.tx_valid && bus.tx_ready;

  always_comb begin
    tmr_load = 1'b0;
    case (state)
      IDLE, BURST_WAIT:            tmr_load = accept;
      SETUP, SCK_LO, SCK_HI, HOLD: tmr_load = tmr_exp;
      default:                     tmr_load = 1'b0;
    endcase
  end

  spi_half_period_timer #(.WIDTH(16)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(RELOAD),
    .expire  (tmr_exp)
  );

  // MISO is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q1 <= 1'b0;
      miso_q2 <= 1'b0;
    end else begin
      miso_q1 <= bus.miso;
      miso_q2 <= miso_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      bit_cnt    <= 3'd0;
      last_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          tx_sh   <= bus.tx_data;
          last_q  <= bus.tx_last;
          bit_cnt <= 3'd0;
          cs_q    <= 1'b0;
          state   <= SETUP;
        end
        SETUP, SCK_LO: if (tmr_exp) begin
          sclk_q <= 1'b1;
          mosi_q <= tx_sh[7];
          state  <= SCK_HI;
        end
        SCK_HI: if (tmr_exp) begin
          sclk_q  <= 1'b0;
          rx_sh   <= {rx_sh[6:0], miso_q2};
          tx_sh   <= {tx_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(SPI_FRAME_BITS - 1)) begin
            rx_data_q  <= {rx_sh[6:0], miso_q2};
            rx_valid_q <= 1'b1;
            state      <= last_q ? HOLD : BURST_WAIT;
          end else begin
            state <= SCK_LO;
          end
        end
        // SCK_LO after a burst accept keeps SCLK low for a full half period.
        BURST_WAIT: if (accept) begin
          tx_sh   <= bus.tx_data;
          last_q  <= bus.tx_last;
          bit_cnt <= 3'd0;
          state   <= SCK_LO;
        end
        HOLD: if (tmr_exp) begin
          cs_q   <= 1'b1;
          mosi_q <= 1'b0;
          state  <= GAP;
        end
        GAP: if (tmr_exp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: timeline model, behavioural SPI slave, literal timing pins.
module tb_spi_master;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if bus();
  spi_master #(.CLK_DIV(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, passed = 0;
  int cyc = 0;
  logic cmp_en = 1'b0;
  logic [7:0] drv_exp_rx = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural slave (mode 1) ----------------
  logic       sl_rst = 1'b0, sl_fixed_mode = 1'b1;
  logic [7:0] sl_fixed = 8'h00, sl_tx = 8'h00, sl_rx = 8'h00, data_received = 8'h00;
  int         sl_bits = 0;
  logic       sclk_d = 1'b0, cs_d = 1'b1;

  always @(posedge clk) begin
    sclk_d <= bus.sclk;
    cs_d   <= bus.cs;
    if (sl_rst) data_received <= 8'h00;
    if (bus.cs) begin
      bus.miso <= 1'b0;
      sl_bits  <= 0;
    end else if (cs_d) begin
      sl_tx <= sl_fixed_mode ? sl_fixed : data_received;
    end else if (bus.sclk && !sclk_d) begin
      bus.miso <= sl_tx[7];
      sl_tx    <= {sl_tx[6:0], 1'b0};
    end else if (!bus.sclk && sclk_d) begin
      sl_rx <= {sl_rx[6:0], bus.mosi};
      if (sl_bits == 7) begin
        data_received <= {sl_rx[6:0], bus.mosi};
        sl_tx   <= sl_fixed_mode ? sl_fixed : {sl_rx[6:0], bus.mosi};
        sl_bits <= 0;
      end else begin
        sl_bits <= sl_bits + 1;
      end
    end
  end

  // ---------------- timeline model ----------------
  // One record per accepted byte; o = cycles since the cycle after accept.
  logic       m_have = 1'b0, m_last = 1'b0, m_prev_mosi = 1'b0;
  logic [7:0] m_byte = 8'h00, m_rx = 8'h00;
  int         m_r = 0;

  function automatic logic e_sclk(input int c);
    int o = c - m_r;
    if (!m_have) return 1'b0;
    return (o >= N) && (o < 17*N) && (((o - N) / N) % 2 == 0);
  endfunction

  function automatic logic e_mosi(input int c);
    int o = c - m_r;
    int k;
    if (!m_have) return 1'b0;
    if (m_last && o >= 17*N) return 1'b0;
    k = (o < N) ? 0 : (o - N) / (2*N) + 1;
    if (k > 8) k = 8;
    return (k == 0) ? m_prev_mosi : m_byte[8-k];
  endfunction

  function automatic logic e_cs(input int c);
    if (!m_have) return 1'b1;
    return m_last && (c - m_r >= 17*N);
  endfunction

  function automatic logic e_rv(input int c);
    return m_have && (c - m_r == 16*N);
  endfunction

  function automatic logic e_rdy(input int c);
    if (!m_have) return 1'b1;
    return m_last ? (c - m_r >= 18*N) : (c - m_r >= 16*N);
  endfunction

  function automatic logic e_busy(input int c);
    if (!m_have) return 1'b0;
    return m_last ? (c - m_r < 18*N) : 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_have <= 1'b0;
    else if (bus.tx_valid && e_rdy(cyc)) begin
      m_have      <= 1'b1;
      m_r         <= cyc + 1;
      m_byte      <= bus.tx_data;
      m_last      <= bus.tx_last;
      m_prev_mosi <= e_mosi(cyc);
      m_rx        <= drv_exp_rx;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cs", bus.cs, e_cs(cyc));
      chk("sclk", bus.sclk, e_sclk(cyc));
      chk("mosi", bus.mosi, e_mosi(cyc));
      chk("rx_valid", bus.rx_valid, e_rv(cyc));
      chk("tx_ready", bus.tx_ready, e_rdy(cyc));
      chk("busy", bus.busy, e_busy(cyc));
      if (e_rv(cyc)) chk("rx_data", bus.rx_data, m_rx);
    end
  end

  // ---------------- event log ----------------
  int   rises[$], falls[$], csf[$], csr[$], rvq[$], rxq[$], rdyq[$], mosiq[$];
  logic sclk_p = 1'b0, cs_p = 1'b1, rdy_p = 1'b1;

  always @(negedge clk) begin
    if (cmp_en) begin
      sclk_p <= bus.sclk;
      cs_p   <= bus.cs;
      rdy_p  <= bus.tx_ready;
      if (bus.sclk && !sclk_p) begin rises.push_back(cyc); mosiq.push_back(int'(bus.mosi)); end
      if (!bus.sclk && sclk_p) falls.push_back(cyc);
      if (!bus.cs && cs_p) csf.push_back(cyc);
      if (bus.cs && !cs_p) csr.push_back(cyc);
      if (bus.rx_valid) begin rvq.push_back(cyc); rxq.push_back(int'(bus.rx_data)); end
      if (bus.tx_ready && !rdy_p) rdyq.push_back(cyc);
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int mosi_byte(input int i);
    int b = 0;
    for (int k = 0; k < 8; k++) b = (b << 1) | ((i + k < mosiq.size()) ? mosiq[i+k] : 0);
    return b;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp_rx, output int acc);
    int n = 0;
    step();
    drv_exp_rx   = exp_rx;
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 5000) begin step(); n++; end
    if (!bus.tx_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    step();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.tx_ready && n < 2000) begin step(); n++; end
    if (!bus.tx_ready) chk({tag, "_ready_timeout"}, 0, 1);
    repeat (2) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, r0, f0, c0, k0, v0, d0;
    logic held;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_ready_in_rst", bus.tx_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_tx_ready_after", bus.tx_ready, 1);
    cmp_en = 1'b1;

    // single byte 0xA5, slave answers 0x3C
    sl_fixed_mode = 1'b1; sl_fixed = 8'h3C;
    r0 = rises.size(); f0 = falls.size(); c0 = csf.size(); k0 = csr.size();
    v0 = rvq.size(); d0 = rdyq.size();
    send(8'hA5, 1'b1, 8'h3C, acc);
    wait_ready("a5");
    chk("a5_cs_fall", qat(csf, c0) - acc, 1);
    chk("a5_first_rise", qat(rises, r0) - acc, 9);
    chk("a5_rx_valid_at", qat(rvq, v0) - acc, 129);
    chk("a5_cs_rise", qat(csr, k0) - acc, 137);
    chk("a5_tx_ready_at", qat(rdyq, d0) - acc, 145);
    chk("a5_mosi_bits", mosi_byte(r0), 8'hA5);
    chk("a5_sclk_edges", (rises.size() - r0) + (falls.size() - f0), 16);
    chk("a5_rx_pulses", rvq.size() - v0, 1);
    chk("a5_rx_data", qat(rxq, v0), 8'h3C);
    chk("a5_slave_rx", data_received, 8'hA5);

    // tx_valid with 0xFF mid-frame must be ignored
    sl_fixed = 8'hC3;
    r0 = rises.size(); v0 = rvq.size(); c0 = csf.size();
    send(8'h69, 1'b1, 8'hC3, acc);
    repeat (40) step();
    bus.tx_data = 8'hFF; bus.tx_last = 1'b1; bus.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin chk("ff_tx_ready", bus.tx_ready, 0); step(); end
    bus.tx_valid = 1'b0;
    wait_ready("ff");
    repeat (20) step();
    chk("ff_mosi_bits", mosi_byte(r0), 8'h69);
    chk("ff_rx_data", qat(rxq, v0), 8'hC3);
    chk("ff_slave_rx", data_received, 8'h69);
    chk("ff_one_frame", csf.size() - c0, 1);

    // reset after rising edge index 4 of 0x0F (MOSI is 1 there)
    r0 = rises.size(); v0 = rvq.size();
    send(8'h0F, 1'b1, 8'h00, acc);
    begin
      int n = 0;
      while (rises.size() < r0 + 5 && n < 500) begin step(); n++; end
      chk("rstmid_reached_bit4", int'(rises.size() >= r0 + 5), 1);
    end
    chk("rstmid_mosi_before", bus.mosi, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_cs", bus.cs, 1);
    chk("rstmid_sclk", bus.sclk, 0);
    chk("rstmid_mosi", bus.mosi, 0);
    chk("rstmid_rx_valid", bus.rx_valid, 0);
    chk("rstmid_busy", bus.busy, 0);
    repeat (3 * N) step();
    chk("rstmid_no_rx", rvq.size() - v0, 0);
    sl_fixed = 8'h7E;
    r0 = rises.size(); v0 = rvq.size();
    send(8'h81, 1'b1, 8'h7E, acc);
    wait_ready("p81");
    chk("p81_mosi_bits", mosi_byte(r0), 8'h81);
    chk("p81_rx_data", qat(rxq, v0), 8'h7E);
    chk("p81_slave_rx", data_received, 8'h81);

    // loopback burst against an echoing slave from power-up state
    sl_fixed_mode = 1'b0;
    sl_rst = 1'b1; step(); sl_rst = 1'b0;
    v0 = rvq.size(); c0 = csf.size(); k0 = csr.size();
    send(8'hA5, 1'b0, 8'h00, acc);
    wait_ready("lb1");
    send(8'h3C, 1'b1, 8'hA5, acc2);
    wait_ready("lb2");
    chk("lb_cs_falls", csf.size() - c0, 1);
    chk("lb_cs_rises", csr.size() - k0, 1);
    chk("lb_cs_rise_after_2nd", int'(qat(csr, k0) > acc2), 1);
    chk("lb_rx0", qat(rxq, v0), 8'h00);
    chk("lb_rx1", qat(rxq, v0 + 1), 8'hA5);
    chk("lb_slave_rx", data_received, 8'h3C);

    // BURST_WAIT stall of 500 cycles, then 0x5A
    sl_fixed_mode = 1'b1; sl_fixed = 8'h11;
    send(8'hA5, 1'b0, 8'h11, acc);
    wait_ready("st1");
    held = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (bus.cs || bus.sclk) held = 1'b0;
      step();
    end
    chk("stall_cs_sclk_low", held, 1);
    r0 = rises.size(); v0 = rvq.size();
    send(8'h5A, 1'b1, 8'h11, acc);
    wait_ready("st2");
    chk("stall_first_rise", qat(rises, r0) - acc, 1 + N);
    chk("stall_mosi_bits", mosi_byte(r0), 8'h5A);
    chk("stall_rx_data", qat(rxq, v0), 8'h11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
